// File: rtl/led_sched_pkg.sv
// Shared types and width helpers for the LED pattern scheduler.
//   mode_t  : per-channel pattern selector (OFF, ON, BLINK, BREATHE)
//   cmd_t   : one pending command {chan, mode}
//   phase_w : counter width for a count range 0..n-1 (never below 1)
//   lvl_w   : width able to hold 0..n inclusive
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef struct packed {
        logic [2:0] chan;
        mode_t      mode;
    } cmd_t;

    function automatic int phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lvl_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_chan_engine.sv
// One LED channel: holds mode, brightness level, breathe direction and
// blink counter, and drives its LED from level versus the shared PWM phase.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_period_end   : strobe marking the PWM period boundary
//   i_apply        : load i_mode into this channel (only with i_period_end)
//   i_mode         : mode to load on apply
//   i_pwm_phase    : shared PWM phase 0..PWM_STEPS-1
//   o_led          : registered LED drive, 1 = lit
module led_chan_engine
    import led_sched_pkg::*;
#(
    parameter int PWM_STEPS     = 1000,
    parameter int BLINK_PERIODS = 250
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_period_end,
    input  logic                            i_apply,
    input  mode_t                           i_mode,
    input  logic [phase_w(PWM_STEPS)-1:0]   i_pwm_phase,
    output logic                            o_led
);

    localparam int PHASE_W = phase_w(PWM_STEPS);
    localparam int LVL_W   = lvl_w(PWM_STEPS);
    localparam int BC_W    = phase_w(BLINK_PERIODS);

    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(PWM_STEPS);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_PERIODS - 1);

    mode_t             r_mode;
    logic [LVL_W-1:0]  r_level;
    logic              r_dir_down;
    logic [BC_W-1:0]   r_blink_cnt;
    logic              r_led;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= MODE_OFF;
            r_level     <= '0;
            r_dir_down  <= 1'b0;
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else begin
            // Level is only ever 0..PWM_STEPS, so level 0 is always dark and
            // level PWM_STEPS beats every phase value.
            r_led <= (r_level > LVL_W'(i_pwm_phase));

            if (i_apply) begin
                // An apply overrides the periodic update and restarts the pattern.
                r_mode <= i_mode;
                case (i_mode)
                    MODE_OFF:     r_level <= '0;
                    MODE_ON:      r_level <= LVL_MAX;
                    MODE_BLINK: begin
                        r_level     <= LVL_MAX;
                        r_blink_cnt <= '0;
                    end
                    MODE_BREATHE: begin
                        r_level    <= '0;
                        r_dir_down <= 1'b0;
                    end
                endcase
            end else if (i_period_end) begin
                case (r_mode)
                    MODE_OFF, MODE_ON: r_level <= r_level;
                    MODE_BLINK: begin
                        if (r_blink_cnt == BC_LAST) begin
                            r_blink_cnt <= '0;
                            r_level     <= (r_level == '0) ? LVL_MAX : '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                    MODE_BREATHE: begin
                        // Turnaround steps straight past the end value so each
                        // extreme is shown for exactly one period.
                        if (!r_dir_down) begin
                            if (r_level == LVL_MAX) begin
                                r_dir_down <= 1'b1;
                                r_level    <= LVL_MAX - 1'b1;
                            end else begin
                                r_level <= r_level + 1'b1;
                            end
                        end else begin
                            if (r_level == '0) begin
                                r_dir_down <= 1'b0;
                                r_level    <= LVL_W'(1);
                            end else begin
                                r_level <= r_level - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler top: shared PWM timebase, single-slot command port,
// and LED_NUM channel engines.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready: command handshake; cmd_chan, cmd_mode carry the command
//   busy               : a command is held and not yet applied
//   period_end         : one-cycle strobe at each PWM period boundary
//   led                : LED drives, 1 = lit
module led_pattern_scheduler
    import led_sched_pkg::*;
#(
    parameter int LED_NUM       = 4,
    parameter int TICK_DIV      = 100,
    parameter int PWM_STEPS     = 1000,
    parameter int BLINK_PERIODS = 250
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_chan,
    input  logic [1:0]         cmd_mode,
    output logic               busy,
    output logic               period_end,
    output logic [LED_NUM-1:0] led
);

    localparam int TICK_W  = phase_w(TICK_DIV);
    localparam int PHASE_W = phase_w(PWM_STEPS);

    logic [TICK_W-1:0]  r_tick_cnt;
    logic [PHASE_W-1:0] r_pwm_phase;
    logic               r_period_end;
    logic               r_busy;
    cmd_t               r_cmd;

    logic w_step_tick;
    logic w_accept;
    logic w_apply;

    assign w_step_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick_cnt   <= '0;
            r_pwm_phase  <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_tick_cnt   <= w_step_tick ? '0 : r_tick_cnt + 1'b1;
            r_period_end <= w_step_tick && (r_pwm_phase == PHASE_W'(PWM_STEPS - 1));
            if (w_step_tick) begin
                r_pwm_phase <= (r_pwm_phase == PHASE_W'(PWM_STEPS - 1)) ? '0
                                                                        : r_pwm_phase + 1'b1;
            end
        end
    end

    // Handshake: a command transfers on any cycle where cmd_valid && cmd_ready.
    // cmd_ready is simply "slot empty", so it never depends on cmd_valid; the
    // slot stays full until the next period_end applies it, and only frees on
    // the cycle after. A command taken on a period_end cycle was not in the
    // slot yet, so it waits a full period.
    assign w_accept = cmd_valid && !r_busy;
    assign w_apply  = r_period_end && r_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_busy <= 1'b0;
            r_cmd  <= '0;
        end else if (w_apply) begin
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_busy     <= 1'b1;
            r_cmd.chan <= cmd_chan;
            r_cmd.mode <= mode_t'(cmd_mode);
        end
    end

    assign cmd_ready  = !r_busy;
    assign busy       = r_busy;
    assign period_end = r_period_end;

    // Out-of-range channel indices match no engine, so they drain silently.
    for (genvar g = 0; g < LED_NUM; g++) begin : g_chan
        logic w_chan_apply;
        assign w_chan_apply = w_apply && (r_cmd.chan == 3'(g));

        led_chan_engine #(
            .PWM_STEPS     (PWM_STEPS),
            .BLINK_PERIODS (BLINK_PERIODS)
        ) u_engine (
            .i_clk        (sys_clk),
            .i_rst_n      (sys_rst_n),
            .i_period_end (r_period_end),
            .i_apply      (w_chan_apply),
            .i_mode       (r_cmd.mode),
            .i_pwm_phase  (r_pwm_phase),
            .o_led        (led[g])
        );
    end

endmodule
